// File: rtl/axis_flit_player.sv
// Buffered AXI-Stream flit player: flits are loaded while idle, then replayed with backpressure and gaps.
// Define AXIS_FLIT_PLAYER_LOOP_EN to add the loop_en input for wrap-around replay.
module axis_flit_player #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 16
) (
    input  logic                   CLK,
    input  logic                   ARESETN,
    input  logic                   load_valid,
    input  logic [DATA_W-1:0]      load_data,
    input  logic [KEEP_W-1:0]      load_keep,
    input  logic                   load_last,
    output logic                   load_ready,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stop,
    input  logic [7:0]             gap_cycles,
`ifdef AXIS_FLIT_PLAYER_LOOP_EN
    input  logic                   loop_en,
`endif
    output logic [DATA_W-1:0]      M_AXIS_tdata,
    output logic [KEEP_W-1:0]      M_AXIS_tkeep,
    output logic                   M_AXIS_tlast,
    output logic                   M_AXIS_tvalid,
    input  logic                   M_AXIS_tready,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       flit_count,
    output logic [CNT_W-1:0]       pkt_count,
    output logic [1:0]             dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam int EW = DATA_W + KEEP_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP, S_FIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [7:0]       gap_q, gap_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Entry layout is {data, keep, last}; contents are deliberately not reset.
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    rd_entry;
    logic             rd_last;
    logic             at_end;
    logic             load_fire;
    logic             beat_fire;
    logic             stop_pend;
    logic             loop_on;
    logic             wrap_stop;

    assign rd_entry  = mem[rd_ptr_q];
    assign rd_last   = rd_entry[0];
    assign at_end    = ({1'b0, rd_ptr_q} == (fill_q - FW'(1)));
    assign stop_pend = stop_q | stop;

    // Handshakes: a load transfers when load_valid & load_ready at CLK; a beat transfers when
    // M_AXIS_tvalid & M_AXIS_tready at CLK. tvalid, once high, holds with stable payload until it transfers.
    assign load_ready = ARESETN & (state_q == S_IDLE) & (fill_q != FW'(DEPTH));
    assign load_fire  = load_valid & load_ready & ~clear;
    assign beat_fire  = M_AXIS_tvalid & M_AXIS_tready;

`ifdef AXIS_FLIT_PLAYER_LOOP_EN
    logic seen_last_q, seen_last_d;
    assign loop_on   = loop_en;
    // With no tlast anywhere in the buffer a pending stop takes effect at the wrap point.
    assign wrap_stop = at_end & ~seen_last_q;
`else
    assign loop_on   = 1'b0;
    assign wrap_stop = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        gap_d      = gap_q;
        stop_d     = stop_q;
        flit_cnt_d = flit_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
`ifdef AXIS_FLIT_PLAYER_LOOP_EN
        seen_last_d = seen_last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                stop_d = 1'b0;
                if (clear) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    fill_d   = '0;
                end else begin
                    if (load_fire) begin
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        fill_d   = fill_q + FW'(1);
                    end
                    if (start) begin
                        if (fill_q != '0) begin
                            state_d    = S_PLAY;
                            rd_ptr_d   = '0;
                            flit_cnt_d = '0;
                            pkt_cnt_d  = '0;
`ifdef AXIS_FLIT_PLAYER_LOOP_EN
                            seen_last_d = 1'b0;
`endif
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_PLAY: begin
                stop_d = stop_pend;
                if (beat_fire) begin
                    flit_cnt_d = flit_cnt_q + CNT_W'(1);
                    rd_ptr_d   = at_end ? '0 : rd_ptr_q + AW'(1);
                    if (rd_last) begin
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
`ifdef AXIS_FLIT_PLAYER_LOOP_EN
                        seen_last_d = 1'b1;
`endif
                    end
                    if (at_end && !loop_on) begin
                        state_d = S_FIN;
                    end else if (rd_last && stop_pend) begin
                        state_d = S_FIN;
                    end else if (wrap_stop && stop_pend) begin
                        state_d = S_FIN;
                    end else if (rd_last && (gap_cycles != 8'd0)) begin
                        state_d = S_GAP;
                        gap_d   = gap_cycles;
                    end
                end
            end
            S_GAP: begin
                stop_d = stop_pend;
                if (stop_pend) begin
                    state_d = S_FIN;
                end else if (gap_q == 8'd1) begin
                    state_d = S_PLAY;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                stop_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            gap_q      <= '0;
            stop_q     <= 1'b0;
            flit_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            gap_q      <= gap_d;
            stop_q     <= stop_d;
            flit_cnt_q <= flit_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

`ifdef AXIS_FLIT_PLAYER_LOOP_EN
    always_ff @(posedge CLK or negedge ARESETN) begin
        if (!ARESETN) begin
            seen_last_q <= 1'b0;
        end else begin
            seen_last_q <= seen_last_d;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (load_fire) begin
            mem[wr_ptr_q] <= {load_data, load_keep, load_last};
        end
    end

    // Payload is forced to zero whenever no beat is offered, so reset also clears it.
    assign M_AXIS_tvalid = (state_q == S_PLAY);
    assign M_AXIS_tdata  = M_AXIS_tvalid ? rd_entry[EW-1 -: DATA_W] : '0;
    assign M_AXIS_tkeep  = M_AXIS_tvalid ? rd_entry[KEEP_W:1] : '0;
    assign M_AXIS_tlast  = M_AXIS_tvalid & rd_last;

    assign fill        = fill_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FIN);
    assign flit_count  = flit_cnt_q;
    assign pkt_count   = pkt_cnt_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_axis_flit_player.sv
// Directed bench for axis_flit_player: scoreboard queue of expected beats, checked by a negedge monitor.
`timescale 1ns/1ps
module tb_axis_flit_player;
    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int DEPTH  = 64;
    localparam int CNT_W  = 16;
    localparam int FW     = 7;
    localparam int EW     = DATA_W + KEEP_W + 1;

    logic              CLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic [KEEP_W-1:0] load_keep = '0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [7:0]        gap_cycles = 8'd0;
`ifdef AXIS_FLIT_PLAYER_LOOP_EN
    logic              loop_en = 1'b0;
`endif
    logic [DATA_W-1:0] M_AXIS_tdata;
    logic [KEEP_W-1:0] M_AXIS_tkeep;
    logic              M_AXIS_tlast;
    logic              M_AXIS_tvalid;
    logic              M_AXIS_tready = 1'b0;
    logic [FW-1:0]     fill;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  flit_count;
    logic [CNT_W-1:0]  pkt_count;
    logic [1:0]        dbg_state_o;

    axis_flit_player #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .ARESETN(ARESETN),
        .load_valid(load_valid), .load_data(load_data), .load_keep(load_keep),
        .load_last(load_last), .load_ready(load_ready),
        .clear(clear), .start(start), .stop(stop), .gap_cycles(gap_cycles),
`ifdef AXIS_FLIT_PLAYER_LOOP_EN
        .loop_en(loop_en),
`endif
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep), .M_AXIS_tlast(M_AXIS_tlast),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready),
        .fill(fill), .busy(busy), .done(done),
        .flit_count(flit_count), .pkt_count(pkt_count), .dbg_state_o(dbg_state_o)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mdl[$];
    int hs_cyc[$];
    int cyc = 0;
    int beats = 0;
    logic held = 1'b0;
    logic [EW-1:0] held_v;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: a beat offered with tready at the negedge transfers at the next posedge.
    always @(negedge CLK) begin
        cyc++;
        if (!ARESETN) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", M_AXIS_tvalid, 1);
                check("hold_payload", {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast}, held_v);
            end
            held = 1'b0;
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                beats++;
                hs_cyc.push_back(cyc);
                check("beat_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0)
                    check("beat_payload", {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast}, exp_q.pop_front());
            end else if (M_AXIS_tvalid) begin
                held   = 1'b1;
                held_v = {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast};
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_flit(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k, input logic l);
        load_valid = 1'b1;
        load_data  = d;
        load_keep  = k;
        load_last  = l;
        tick();
        load_valid = 1'b0;
        mdl.push_back({d, k, l});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        mdl.delete();
    endtask

    task automatic start_play(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(mdl[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cycles);
        int n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (n < 300 && !seen) begin
            @(negedge CLK);
            n++;
            seen = done;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (exp_cycles >= 0) check({tag, "_done_cycles"}, n, exp_cycles);
        tick();
    endtask

    logic [63:0] t_data [4];
    logic [7:0]  t_keep [4];
    logic        t_last [4];
    logic        pat    [7];
    int          b0;
    int          n;
    int          exp_pkts;

    initial begin
        t_data = '{64'h4c0c02ca553e16fa, 64'h0000007447c0887a, 64'h0100000100030000, 64'h5073930200000000};
        t_keep = '{8'hff, 8'hff, 8'hff, 8'h0f};
        t_last = '{1'b0, 1'b0, 1'b0, 1'b1};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset values
        #3;
        check("rst_tvalid", M_AXIS_tvalid, 0);
        check("rst_tdata", {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast}, 0);
        check("rst_load_ready", load_ready, 0);
        check("rst_fill", fill, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_counts", {flit_count, pkt_count}, 0);
        check("rst_state", dbg_state_o, 0);
        @(posedge CLK);
        #1;
        ARESETN = 1'b1;
        #1;
        check("post_rst_load_ready", load_ready, 1);

        // Basic 4-flit packet at full rate
        for (int i = 0; i < 4; i++) load_flit(t_data[i], t_keep[i], t_last[i]);
        check("fill_4", fill, 4);
        M_AXIS_tready = 1'b1;
        gap_cycles = 8'd0;
        b0 = beats;
        start_play(4);
        check("busy_play", busy, 1);
        wait_done("basic", 5);
        check("basic_beats", beats - b0, 4);
        check("basic_flit_count", flit_count, 4);
        check("basic_pkt_count", pkt_count, 1);
        check("basic_idle", busy, 0);
        check("basic_fill_kept", fill, 4);

        // Same buffer with backpressure pattern
        M_AXIS_tready = 1'b0;
        b0 = beats;
        start_play(4);
        for (int i = 0; i < 7; i++) begin
            M_AXIS_tready = pat[i];
            tick();
        end
        M_AXIS_tready = 1'b1;
        wait_done("bp", 1);
        check("bp_beats", beats - b0, 4);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_flit_count", flit_count, 4);

        // Two 2-flit packets with a 3-cycle gap
        do_clear();
        for (int i = 0; i < 4; i++) load_flit({$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'(i % 2));
        gap_cycles = 8'd3;
        hs_cyc.delete();
        start_play(4);
        wait_done("gap", 8);
        check("gap_beats", hs_cyc.size(), 4);
        if (hs_cyc.size() == 4) begin
            check("gap_b1_b2", hs_cyc[1] - hs_cyc[0], 1);
            check("gap_b2_b3", hs_cyc[2] - hs_cyc[1], 4);
            check("gap_b3_b4", hs_cyc[3] - hs_cyc[2], 1);
        end
        check("gap_pkt_count", pkt_count, 2);
        gap_cycles = 8'd0;

        // Full buffer, overflow attempt, random backpressure replay
        do_clear();
        exp_pkts = 0;
        for (int i = 0; i < DEPTH; i++) begin
            load_flit({$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if (mdl[i][0]) exp_pkts++;
        end
        check("full_fill", fill, DEPTH);
        check("full_load_ready", load_ready, 0);
        load_valid = 1'b1;
        load_data  = 64'hdead_beef_0000_0001;
        tick();
        load_valid = 1'b0;
        check("overflow_fill", fill, DEPTH);
        b0 = beats;
        start_play(DEPTH);
        n = 0;
        while (!done && n < 2000) begin
            M_AXIS_tready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("full_done", done, 1);
        tick();
        M_AXIS_tready = 1'b1;
        check("full_beats", beats - b0, DEPTH);
        check("full_flit_count", flit_count, DEPTH);
        check("full_pkt_count", pkt_count, exp_pkts);
        do_clear();
        check("clear_fill", fill, 0);
        b0 = beats;
        start_play(0);
        wait_done("empty", 1);
        check("empty_beats", beats - b0, 0);

        // Stop during beat 1 of a 2-packet buffer
        for (int i = 0; i < 4; i++) load_flit({$urandom, $urandom}, 8'hff, 1'(i % 2));
        start_play(2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("stop", 2);
        check("stop_pkt_count", pkt_count, 1);
        check("stop_flit_count", flit_count, 2);
        check("stop_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a stalled beat
        M_AXIS_tready = 1'b0;
        start_play(0);
        @(negedge CLK);
        #2;
        ARESETN = 1'b0;
        #1;
        check("abort_tvalid", M_AXIS_tvalid, 0);
        check("abort_fill", fill, 0);
        check("abort_busy", busy, 0);
        @(posedge CLK);
        #1;
        ARESETN = 1'b1;
        #1;
        check("abort_load_ready", load_ready, 1);
        mdl.delete();
        exp_q.delete();
        M_AXIS_tready = 1'b1;

`ifdef AXIS_FLIT_PLAYER_LOOP_EN
        // Looping replay, stop at beat 6 ends after beat 8
        for (int i = 0; i < 4; i++) load_flit(t_data[i], t_keep[i], t_last[i]);
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(mdl[i]);
        b0 = beats;
        start_play(4);
        for (int i = 0; i < 5; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("loop", 3);
        check("loop_beats", beats - b0, 8);
        check("loop_pkt_count", pkt_count, 2);
        check("loop_flit_count", flit_count, 8);
        loop_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
